// File: rtl/imu_burst_reader.sv
// imu_burst_reader: reads 2*NUM_AXES consecutive I2C registers one byte at a
// time through a single-byte I2C master. It pairs the bytes into 16-bit samples
// and publishes all axes together with a one-cycle sample_valid strobe.
// Optional feature: define IMU_READER_WATCHDOG_EN to abort a transaction that
// gets no i2c_done within TIMEOUT_CYCLES clocks. The abort sets the sticky
// error flag.
module imu_burst_reader #(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter logic [6:0] BASE_REG       = 7'h12,
  parameter int         NUM_AXES       = 3,
  parameter bit         LSB_FIRST      = 1'b1,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  output logic                    busy,
  output logic                    sample_valid,
  output logic [16*NUM_AXES-1:0]  samples,
  output logic                    error,
  output logic                    i2c_start,
  output logic                    i2c_read_write,
  output logic [6:0]              i2c_slave_addr,
  output logic [6:0]              i2c_reg_addr,
  output logic [7:0]              i2c_data_in,
  input  logic [7:0]              i2c_data_out,
  input  logic                    i2c_busy,
  input  logic                    i2c_done
);

  localparam int         NUM_BYTES = 2 * NUM_AXES;
  localparam logic [2:0] LAST_IDX  = 3'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shadow_q [NUM_BYTES];
  logic [7:0]             shadow_d [NUM_BYTES];
  logic [16*NUM_AXES-1:0] samples_q, samples_d;
  logic [16*NUM_AXES-1:0] packed_next;
  logic                   accept;
  logic                   store_en;
  logic                   last_byte;
  logic                   timeout;

  // A new burst starts only from IDLE and only when the master is free
  assign accept    = (state_q == IDLE) && trigger && !i2c_busy;
  assign store_en  = (state_q == WAIT) && i2c_done;
  assign last_byte = (idx_q == LAST_IDX);

`ifdef IMU_READER_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  // Cycle counter is held at zero outside WAIT, so each entry into WAIT starts from 0
  always_comb begin
    wd_d = '0;
    if (state_q == WAIT) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // The last counted WAIT cycle without a done aborts the transaction; a done in that cycle still wins
  assign timeout = (state_q == WAIT) && !i2c_done && (wd_q == WD_LAST);

  // The error flag stays set until the next accepted trigger
  always_comb begin
    error_d = error_q;
    if (accept) begin
      error_d = 1'b0;
    end else if (timeout) begin
      error_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // Next-state and byte-index logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          if (last_byte) begin
            state_d = PUBLISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ISSUE;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the returned byte into its shadow slot; done strobes outside WAIT never land here
  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      shadow_d[i] = shadow_q[i];
      if (store_en && (idx_q == 3'(i))) begin
        shadow_d[i] = i2c_data_out;
      end
    end
  end

  // Pair the shadow bytes into samples. This uses the post-store view so the last
  // byte is included in the same cycle it arrives.
  generate
    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_pack
      if (LSB_FIRST) begin : g_lsb_first
        assign packed_next[16*gi +: 16] = {shadow_d[2*gi+1], shadow_d[2*gi]};
      end else begin : g_msb_first
        assign packed_next[16*gi +: 16] = {shadow_d[2*gi], shadow_d[2*gi+1]};
      end
    end
  endgenerate

  // Samples load only when the final byte completes the burst, so they are
  // already stable in the PUBLISH cycle that strobes sample_valid
  always_comb begin
    samples_d = samples_q;
    if (store_en && last_byte) begin
      samples_d = packed_next;
    end
  end

  // State, index, shadow and sample registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      samples_q <= '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      samples_q <= samples_d;
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign sample_valid   = (state_q == PUBLISH);
  assign samples        = samples_q;
  assign i2c_start      = (state_q == ISSUE);
  assign i2c_read_write = 1'b1;
  assign i2c_slave_addr = DEV_ADDR;
  assign i2c_reg_addr   = BASE_REG + {4'b0000, idx_q};
  assign i2c_data_in    = 8'h00;

endmodule

// File: tb/tb_imu_burst_reader.sv
// Self-checking bench for imu_burst_reader. DUT a uses the defaults. DUT b uses
// NUM_AXES=1, LSB_FIRST=0, BASE_REG=7'h7F and TIMEOUT_CYCLES=16. Each DUT talks
// to a behavioural I2C master model that has its own register memory.
`timescale 1ns/1ps
module tb_imu_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- DUT a (defaults) ----------------
  logic        a_trig, a_busy, a_sv, a_err, a_start, a_rw, a_ibusy, a_done;
  logic [47:0] a_samples;
  logic [6:0]  a_slv, a_reg;
  logic [7:0]  a_din, a_dout;

  imu_burst_reader u_a (
    .clk(clk), .rst(rst), .trigger(a_trig), .busy(a_busy), .sample_valid(a_sv),
    .samples(a_samples), .error(a_err), .i2c_start(a_start), .i2c_read_write(a_rw),
    .i2c_slave_addr(a_slv), .i2c_reg_addr(a_reg), .i2c_data_in(a_din),
    .i2c_data_out(a_dout), .i2c_busy(a_ibusy), .i2c_done(a_done)
  );

  // ---------------- DUT b (1 axis, MSB first, wrapping base) ----------------
  logic        b_trig, b_busy, b_sv, b_err, b_start, b_rw, b_ibusy, b_done;
  logic [15:0] b_samples;
  logic [6:0]  b_slv, b_reg;
  logic [7:0]  b_din, b_dout;

  imu_burst_reader #(
    .DEV_ADDR(7'h68), .BASE_REG(7'h7F), .NUM_AXES(1), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)
  ) u_b (
    .clk(clk), .rst(rst), .trigger(b_trig), .busy(b_busy), .sample_valid(b_sv),
    .samples(b_samples), .error(b_err), .i2c_start(b_start), .i2c_read_write(b_rw),
    .i2c_slave_addr(b_slv), .i2c_reg_addr(b_reg), .i2c_data_in(b_din),
    .i2c_data_out(b_dout), .i2c_busy(b_ibusy), .i2c_done(b_done)
  );

  // ---------------- I2C master models ----------------
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  int         a_cnt, b_cnt;
  logic [6:0] a_addr_l, b_addr_l;
  logic       a_rdone, a_rbusy, b_rdone, b_rbusy;
  logic [7:0] a_rdata, b_rdata;
  logic       a_force_busy, a_spur, b_mute;
  logic [7:0] a_spur_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= 0; a_rdone <= 1'b0; a_rbusy <= 1'b0; a_rdata <= 8'h00; a_addr_l <= 7'h00;
    end else begin
      a_rdone <= 1'b0;
      if (a_cnt == 0) begin
        if (a_start) begin
          a_cnt <= int'($urandom_range(1, 4)); a_rbusy <= 1'b1; a_addr_l <= a_reg;
        end
      end else if (a_cnt == 1) begin
        a_cnt <= 0; a_rbusy <= 1'b0; a_rdone <= 1'b1; a_rdata <= mem_a[a_addr_l];
      end else begin
        a_cnt <= a_cnt - 1;
      end
    end
  end
  assign a_done  = a_rdone | a_spur;
  assign a_dout  = a_spur ? a_spur_data : a_rdata;
  assign a_ibusy = a_rbusy | a_force_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cnt <= 0; b_rdone <= 1'b0; b_rbusy <= 1'b0; b_rdata <= 8'h00; b_addr_l <= 7'h00;
    end else begin
      b_rdone <= 1'b0;
      if (b_cnt == 0) begin
        if (b_start && !b_mute) begin
          b_cnt <= int'($urandom_range(1, 4)); b_rbusy <= 1'b1; b_addr_l <= b_reg;
        end
      end else if (b_cnt == 1) begin
        b_cnt <= 0; b_rbusy <= 1'b0; b_rdone <= 1'b1; b_rdata <= mem_b[b_addr_l];
      end else begin
        b_cnt <= b_cnt - 1;
      end
    end
  end
  assign b_done  = b_rdone;
  assign b_dout  = b_rdata;
  assign b_ibusy = b_rbusy;

  // ---------------- protocol monitors (sampled mid-cycle) ----------------
  logic [6:0]  a_addr_q[$], b_addr_q[$];
  int          a_start_cyc[$], a_sv_cyc[$], b_start_cyc[$], b_sv_cyc[$];
  logic [47:0] a_sv_samples[$];
  logic [15:0] b_sv_samples[$];
  logic        a_start_prev = 1'b0, a_done_prev = 1'b0, b_start_prev = 1'b0, b_done_prev = 1'b0;
  int          a_last_done = -10, b_last_done = -10;
  int          a_bad_width = 0, a_bad_busy = 0, a_bad_seq = 0, a_bad_sv = 0, b_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_start) begin
        a_addr_q.push_back(a_reg);
        a_start_cyc.push_back(cyc);
      end
      if (a_sv) begin
        a_sv_cyc.push_back(cyc);
        a_sv_samples.push_back(a_samples);
      end
      if (a_start && a_start_prev) a_bad_width <= a_bad_width + 1;
      if (a_start && a_ibusy) a_bad_busy <= a_bad_busy + 1;
      if (a_done_prev && !a_start && !a_sv) a_bad_seq <= a_bad_seq + 1;
      if (a_sv && (a_last_done != cyc - 1)) a_bad_sv <= a_bad_sv + 1;
      if (a_done && a_busy) a_last_done <= cyc;
      a_start_prev <= a_start;
      a_done_prev  <= a_done && a_busy;

      if (b_start) begin
        b_addr_q.push_back(b_reg);
        b_start_cyc.push_back(cyc);
      end
      if (b_sv) begin
        b_sv_cyc.push_back(cyc);
        b_sv_samples.push_back(b_samples);
      end
      b_bad <= b_bad + ((b_start && b_start_prev) ? 1 : 0) + ((b_start && b_ibusy) ? 1 : 0)
                     + ((b_done_prev && !b_start && !b_sv) ? 1 : 0)
                     + ((b_sv && (b_last_done != cyc - 1)) ? 1 : 0);
      if (b_done && b_busy) b_last_done <= cyc;
      b_start_prev <= b_start;
      b_done_prev  <= b_done && b_busy;
    end else begin
      a_start_prev <= 1'b0; a_done_prev <= 1'b0;
      b_start_prev <= 1'b0; b_done_prev <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Each sample is a 16-bit number built from two bytes at consecutive register
  // addresses, counted from the burst base modulo 128
  function automatic logic [47:0] model_a();
    longint r = 0;
    for (int k = 0; k < 3; k++) begin
      int lo = int'(mem_a[(8'h12 + 2*k) % 128]);
      int hi = int'(mem_a[(8'h12 + 2*k + 1) % 128]);
      r += longint'(hi * 256 + lo) << (16 * k);
    end
    return r[47:0];
  endfunction

  function automatic logic [15:0] model_b();
    int hi = int'(mem_b[8'h7F % 128]);
    int lo = int'(mem_b[(8'h7F + 1) % 128]);
    return 16'(hi * 256 + lo);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sv_a(input int target, input string tag);
    int n = 0;
    while (a_sv_cyc.size() < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_sv_count"}, 64'(a_sv_cyc.size()), 64'(target));
  endtask

  task automatic wait_sv_b(input int target, input string tag);
    int n = 0;
    while (b_sv_cyc.size() < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_sv_count"}, 64'(b_sv_cyc.size()), 64'(target));
  endtask

  // One triggered burst on DUT a with every observable effect checked
  task automatic run_a(input string tag);
    int s0 = a_start_cyc.size();
    int v0 = a_sv_cyc.size();
    int t;
    logic [47:0] exp = model_a();
    @(posedge clk); #1; a_trig = 1'b1; t = cyc;
    @(posedge clk); #1; a_trig = 1'b0;
    wait_sv_a(v0 + 1, tag);
    check({tag, "_first_start_cyc"}, 64'((a_start_cyc.size() > s0) ? a_start_cyc[s0] : -1), 64'(t + 1));
    check({tag, "_num_starts"}, 64'(a_start_cyc.size()), 64'(s0 + 6));
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_reg_addr%0d", tag, i),
            64'((a_addr_q.size() > s0 + i) ? a_addr_q[s0 + i] : 7'h00), 64'((8'h12 + i) % 128));
    check({tag, "_sv_samples"}, 64'((a_sv_samples.size() > v0) ? a_sv_samples[v0] : 48'h0), 64'(exp));
    check({tag, "_samples_hold"}, 64'(a_samples), 64'(exp));
    check({tag, "_busy_after"}, 64'(a_busy), 64'(0));
    $display("burst a %s: samples=%h expected=%h", tag, a_samples, exp);
  endtask

  task automatic run_b(input string tag);
    int s0 = b_start_cyc.size();
    int v0 = b_sv_cyc.size();
    int t;
    logic [15:0] exp = model_b();
    @(posedge clk); #1; b_trig = 1'b1; t = cyc;
    @(posedge clk); #1; b_trig = 1'b0;
    check({tag, "_error_cleared"}, 64'(b_err), 64'(0));
    wait_sv_b(v0 + 1, tag);
    check({tag, "_first_start_cyc"}, 64'((b_start_cyc.size() > s0) ? b_start_cyc[s0] : -1), 64'(t + 1));
    check({tag, "_num_starts"}, 64'(b_start_cyc.size()), 64'(s0 + 2));
    check({tag, "_reg_addr0"}, 64'((b_addr_q.size() > s0) ? b_addr_q[s0] : 7'h01), 64'(8'h7F % 128));
    check({tag, "_reg_addr1"}, 64'((b_addr_q.size() > s0 + 1) ? b_addr_q[s0 + 1] : 7'h01), 64'((8'h7F + 1) % 128));
    check({tag, "_samples"}, 64'(b_samples), 64'(exp));
    $display("burst b %s: samples=%h expected=%h", tag, b_samples, exp);
  endtask

  initial begin
    int s0, v0, t, n, cnt;
    logic [47:0] exp_a;
    logic [15:0] exp_b;

    rst = 1'b1; a_trig = 1'b0; b_trig = 1'b0;
    a_force_busy = 1'b0; a_spur = 1'b0; a_spur_data = 8'h00; b_mute = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_sv", 64'(a_sv), 64'(0));
    check("rst_samples", 64'(a_samples), 64'(0));
    check("rst_error", 64'(a_err), 64'(0));
    check("rst_start", 64'(a_start), 64'(0));
    check("rst_reg_addr", 64'(a_reg), 64'(7'h12));
    check("const_rw", 64'(a_rw), 64'(1));
    check("const_slave", 64'(a_slv), 64'(7'h68));
    check("const_data_in", 64'(a_din), 64'(0));
    check("rst_b_reg_addr", 64'(b_reg), 64'(7'h7F));
    check("rst_b_samples", 64'(b_samples), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed burst with the known byte pattern
    for (int i = 0; i < 6; i++) mem_a[8'h12 + i] = 8'(8'h11 * (i + 1));
    run_a("directed");
    check("directed_literal", 64'(a_samples), 64'(48'h6655_4433_2211));

    // Random register contents
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
      run_a($sformatf("rand%0d", r));
    end

    // Master busy holds the request off in IDLE
    s0 = a_start_cyc.size(); v0 = a_sv_cyc.size(); exp_a = model_a();
    @(posedge clk); #1; a_force_busy = 1'b1; a_trig = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("busy_block_starts", 64'(a_start_cyc.size()), 64'(s0));
    check("busy_block_idle", 64'(a_busy), 64'(0));
    a_force_busy = 1'b0; t = cyc;
    @(posedge clk); #1; a_trig = 1'b0;
    wait_sv_a(v0 + 1, "busy_block");
    check("busy_block_start_cyc", 64'((a_start_cyc.size() > s0) ? a_start_cyc[s0] : -1), 64'(t + 1));
    check("busy_block_samples", 64'(a_samples), 64'(exp_a));

    // Trigger held high: three back-to-back bursts
    for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
    exp_a = model_a();
    s0 = a_start_cyc.size(); v0 = a_sv_cyc.size();
    @(posedge clk); #1; a_trig = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 3 && n < 3000) begin
      @(negedge clk); n++;
      if (a_sv) cnt++;
    end
    a_trig = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("held_sv_count", 64'(a_sv_cyc.size()), 64'(v0 + 3));
    check("held_num_starts", 64'(a_start_cyc.size()), 64'(s0 + 18));
    for (int b = 0; b < 3; b++)
      check($sformatf("held_samples%0d", b),
            64'((a_sv_samples.size() > v0 + b) ? a_sv_samples[v0 + b] : 48'h0), 64'(exp_a));
    for (int b = 1; b < 3; b++)
      check($sformatf("held_retrigger_gap%0d", b),
            64'((a_start_cyc.size() > s0 + 6*b && a_sv_cyc.size() > v0 + b - 1) ?
                a_start_cyc[s0 + 6*b] - a_sv_cyc[v0 + b - 1] : -1), 64'(2));

    // Trigger pulse while busy, then a spurious done in IDLE
    for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
    exp_a = model_a();
    s0 = a_start_cyc.size(); v0 = a_sv_cyc.size();
    @(posedge clk); #1; a_trig = 1'b1;
    @(posedge clk); #1; a_trig = 1'b0;
    n = 0;
    while (a_start_cyc.size() < s0 + 2 && n < 200) begin @(posedge clk); #1; n++; end
    a_trig = 1'b1;
    @(posedge clk); #1; a_trig = 1'b0;
    wait_sv_a(v0 + 1, "ignore_trig");
    repeat (3) begin @(posedge clk); #1; end
    a_spur = 1'b1; a_spur_data = 8'hEE;
    @(posedge clk); #1; a_spur = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("ignore_sv_count", 64'(a_sv_cyc.size()), 64'(v0 + 1));
    check("ignore_num_starts", 64'(a_start_cyc.size()), 64'(s0 + 6));
    check("ignore_samples", 64'(a_samples), 64'(exp_a));
    check("ignore_busy", 64'(a_busy), 64'(0));

    // Reset after the third done of a burst
    for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
    v0 = a_sv_cyc.size();
    @(posedge clk); #1; a_trig = 1'b1;
    @(posedge clk); #1; a_trig = 1'b0;
    n = 0; cnt = 0;
    while (cnt < 3 && n < 200) begin
      @(negedge clk); n++;
      if (a_done && a_busy) cnt++;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(a_busy), 64'(0));
    check("midrst_sv", 64'(a_sv), 64'(0));
    check("midrst_samples", 64'(a_samples), 64'(0));
    check("midrst_start", 64'(a_start), 64'(0));
    check("midrst_reg_addr", 64'(a_reg), 64'(7'h12));
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_no_sv", 64'(a_sv_cyc.size()), 64'(v0));
    run_a("after_rst");

    // DUT b: MSB first, register window wraps from 7F to 00
    mem_b[7'h7F] = 8'hAB; mem_b[7'h00] = 8'hCD;
    run_b("b_wrap");
    check("b_wrap_literal", 64'(b_samples), 64'(16'hABCD));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
      run_b($sformatf("b_rand%0d", r));
    end

`ifdef IMU_READER_WATCHDOG_EN
    // Watchdog: the master never answers
    exp_b = b_samples;
    s0 = b_start_cyc.size(); v0 = b_sv_cyc.size();
    b_mute = 1'b1;
    @(posedge clk); #1; b_trig = 1'b1; t = cyc;
    @(posedge clk); #1; b_trig = 1'b0;
    while (cyc < t + 17) begin @(posedge clk); #1; end
    check("wd_error_before", 64'(b_err), 64'(0));
    check("wd_busy_before", 64'(b_busy), 64'(1));
    @(posedge clk); #1;
    check("wd_error_set", 64'(b_err), 64'(1));
    check("wd_busy_after", 64'(b_busy), 64'(0));
    repeat (4) begin @(posedge clk); #1; end
    check("wd_error_sticky", 64'(b_err), 64'(1));
    check("wd_samples_kept", 64'(b_samples), 64'(exp_b));
    check("wd_no_sv", 64'(b_sv_cyc.size()), 64'(v0));
    check("wd_one_start", 64'(b_start_cyc.size()), 64'(s0 + 1));
    b_mute = 1'b0;
    for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
    run_b("wd_recover");
`else
    exp_b = model_b();
    check("no_wd_error_low", 64'(b_err), 64'(0));
    check("no_wd_samples", 64'(b_samples), 64'(exp_b));
`endif

    check("a_start_width", 64'(a_bad_width), 64'(0));
    check("a_start_while_busy", 64'(a_bad_busy), 64'(0));
    check("a_done_to_next", 64'(a_bad_seq), 64'(0));
    check("a_sv_after_done", 64'(a_bad_sv), 64'(0));
    check("b_protocol", 64'(b_bad), 64'(0));
    check("a_error_low", 64'(a_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
